conv_data_loader: RTL and testbench
===================================

Name: conv_data_loader

Overview:
- Feeds one processing element with IFMap/filter operand pairs for a 1-D sliding-window convolution.
- Raw words enter through two small input FIFOs.
- Words drain into an IFMap circular scratchpad (row-tagged) and a filter scratchpad.
- A read-address FSM walks windows of `filter_size` words at `stride` spacing over each row and emits one operand pair per cycle.

Parameters:
- IF_W, 16: IFMap data width. Input words are IF_W+2 bits: bit IF_W+1 = start-of-row, bit IF_W = end-of-row.
- FLT_W, 16: filter data width.
- IF_DEPTH, 12: IFMap scratchpad words (circular).
- FLT_DEPTH, 16: filter scratchpad words.
- IF_AW, 4: IFMap address width.
- FLT_AW, 4: filter address width.
- N_W, 4: width of row count `n`.
- PAR_IF, 1: IFMap words per input write.
- PAR_FLT, 1: filter words per input write.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins processing `n` rows.
- stall  in  1  freezes the read FSM.
- if_clr  in  1  synchronous flush of the IFMap input FIFO.
- if_wen  in  1  IFMap input write.
- flt_clr  in  1  synchronous flush of the filter input FIFO.
- flt_wen  in  1  filter input write.
- stride  in  IF_AW  window step.
- filter_size  in  FLT_AW  window length, 1..FLT_DEPTH.
- n  in  N_W  rows per start, at least 1.
- if_din  in  PAR_IF*(IF_W+2)  IFMap words; slice 0 is enqueued first.
- flt_din  in  PAR_FLT*FLT_W  filter words; slice 0 is enqueued first.
- if_ready  out  1  IFMap input FIFO has at least PAR_IF free entries.
- flt_ready  out  1  filter input FIFO has at least PAR_FLT free entries.
- if_dout  out  IF_W  IFMap operand.
- flt_dout  out  FLT_W  filter operand.
- valid  out  1  operand pair valid.
- done  out  1  one-cycle pulse after the last operand of row n.

Behaviour:
- Reset: FIFOs empty, all pointers and counters 0, FSM IDLE. Outputs: if_dout=0, flt_dout=0, valid=0, done=0, if_ready=1, flt_ready=1.
- Input FIFOs:
  - Depth 4 entries each.
  - A write when ready=0 is ignored.
  - Clear has priority over a simultaneous write.
- Drain (one word per cycle per FIFO, combinational handshake):
  - IFMap: pops when FIFO is non-empty AND (row-start queue empty OR IF write pointer != oldest queued row start). This prevents overwriting an unread row.
  - Filter: pops while fewer than FLT_DEPTH words have been loaded. After FLT_DEPTH words, load_done is set (sticky until reset) and the filter drain stops.
  - IF write pointer wraps from IF_DEPTH-1 to 0.
  - Filter write pointer runs 0..FLT_DEPTH-1.
- Row tags:
  - On an IFMap pop with the start bit set, the write address is pushed into a 2-entry row-start queue.
  - On a pop with the end bit set, the write address is pushed into a 2-entry row-end queue.
  - A single word may carry both bits.
- Read FSM states:
  - IDLE: on start, latch n; rows_left=n; go to WAIT.
  - WAIT: when the row-start queue is non-empty, base=head, off=0, j=0; go to READ.
  - READ:
    - Each non-stalled cycle, issue IF addr=(base+off+j) mod IF_DEPTH and filter addr=j.
    - Issue only if the IF word is written (addr != IF write pointer, or the row-end queue holds this row) and filter addr < filter count (or load_done). Otherwise wait.
    - j increments up to filter_size-1. At wrap, j=0 and off+=stride.
    - When off+stride+filter_size-1 exceeds the row length (end-base mod IF_DEPTH), the row is finished once the last issue of the current window completes: pop both row queues and decrement rows_left.
    - rows_left=0 → DONE; else → WAIT.
  - DONE: assert done for one cycle; go to IDLE.
- Output timing:
  - Scratchpads are read synchronously: data appears 1 cycle after its address is issued.
  - valid = issued_last_cycle AND (if_dout != 0). Zero IFMap words are consumed but never flagged valid.
  - Stall holds addresses and j/off. Cycles with stall=1 produce valid=0 next cycle.
- A start received while not IDLE is ignored.
- rst in mid-operation aborts immediately to the reset state.

Decomposition:
- Package `conv_dl_pkg`: FSM state enum {IDLE, WAIT, READ, DONE} and default parameter constants.
- Sub-module `dl_fifo`: parameterised width/depth, parallel write, single read, clear, ready/valid. Used four times: both input FIFOs and both row queues.

Test Plan:
1. Reset, then write 8 IFMap words tagged start…end with values 1..8, 16 filter words 1..16, filter_size=4, stride=4, n=1, start. Expect 8 valid pairs: (1,1)(2,2)(3,3)(4,4)(5,1)(6,2)(7,3)(8,4), then done one cycle after the last.
2. Same as 1 but IFMap word 3 = 0. Expect the third pair cycle to have valid=0; the other 7 valid; done unchanged.
3. Two rows of 8 words, n=2; the second row wraps the 12-word scratchpad. Expect 16 valid pairs with correct wrapped data, then a single done.
4. Hold stall=1 for 3 cycles mid-window. Expect no valid during the stall, the stream to resume on the same (IF, filter) pair, and no pair skipped or duplicated.
5. Issue if_wen bursts while if_ready=0. Expect dropped writes and FIFO contents unchanged. Assert if_clr together with if_wen: FIFO empty afterwards.
6. Delay filter writes until after start. Expect valid to stay 0 until each filter word arrives; output ordering unchanged.

Source files
------------

// File: rtl/conv_dl_pkg.sv
// Shared types and default sizing for the convolution data loader.
package conv_dl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_IF_W      = 16;
    localparam int DEF_FLT_W     = 16;
    localparam int DEF_IF_DEPTH  = 12;
    localparam int DEF_FLT_DEPTH = 16;
    localparam int DEF_IF_AW     = 4;
    localparam int DEF_FLT_AW    = 4;
    localparam int DEF_N_W       = 4;
    localparam int DEF_PAR_IF    = 1;
    localparam int DEF_PAR_FLT   = 1;

    localparam int IN_FIFO_DEPTH = 4;
    localparam int TAG_Q_DEPTH   = 2;

endpackage

// File: rtl/dl_fifo.sv
// Small circular FIFO: PAR words per write (slice 0 first), one word per read,
// synchronous clear with priority over write and read.
module dl_fifo
    import conv_dl_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = IN_FIFO_DEPTH,
    parameter int PAR   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wen,
    input  logic [PAR*W-1:0] din,
    output logic             ready,
    input  logic             ren,
    output logic [W-1:0]     dout,
    output logic             valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr, do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign ready = (count_q <= CW'(DEPTH - PAR));
    assign valid = (count_q != '0);
    assign dout  = mem_q[rd_ptr_q];
    assign do_wr = wen && ready && !clr;
    assign do_rd = ren && valid && !clr;

    // Next storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                for (int unsigned i = 0; i < PAR; i++) begin
                    mem_d[wr_ptr_d] = din[i*W +: W];
                    wr_ptr_d        = ptr_inc(wr_ptr_d);
                end
                count_d = count_d + CW'(PAR);
            end
            if (do_rd) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_d - CW'(1);
            end
        end
    end

    // FIFO state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/conv_data_loader.sv
// Sliding-window operand feeder: input FIFOs drain into an IFMap circular
// scratchpad and a filter scratchpad; a read FSM walks windows over each row.
module conv_data_loader
    import conv_dl_pkg::*;
#(
    parameter int IF_W      = DEF_IF_W,
    parameter int FLT_W     = DEF_FLT_W,
    parameter int IF_DEPTH  = DEF_IF_DEPTH,
    parameter int FLT_DEPTH = DEF_FLT_DEPTH,
    parameter int IF_AW     = DEF_IF_AW,
    parameter int FLT_AW    = DEF_FLT_AW,
    parameter int N_W       = DEF_N_W,
    parameter int PAR_IF    = DEF_PAR_IF,
    parameter int PAR_FLT   = DEF_PAR_FLT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       if_clr,
    input  logic                       if_wen,
    input  logic                       flt_clr,
    input  logic                       flt_wen,
    input  logic [IF_AW-1:0]           stride,
    input  logic [FLT_AW-1:0]          filter_size,
    input  logic [N_W-1:0]             n,
    input  logic [PAR_IF*(IF_W+2)-1:0] if_din,
    input  logic [PAR_FLT*FLT_W-1:0]   flt_din,
    output logic                       if_ready,
    output logic                       flt_ready,
    output logic [IF_W-1:0]            if_dout,
    output logic [FLT_W-1:0]           flt_dout,
    output logic                       valid,
    output logic                       done
);

    localparam int WW  = IF_W + 2;
    localparam int MX  = (IF_AW > FLT_AW) ? IF_AW : FLT_AW;
    localparam int SW  = MX + 2;
    localparam int FCW = FLT_AW + 1;

    logic [WW-1:0]    if_head;
    logic [FLT_W-1:0] flt_head;
    logic             if_avail, flt_avail, if_pop, flt_pop;
    logic [IF_AW-1:0] rs_head, re_head;
    logic             rs_valid, re_valid, rs_ready, re_ready, row_pop;

    logic [IF_W-1:0]  if_spad_q [IF_DEPTH];
    logic [IF_W-1:0]  if_spad_d [IF_DEPTH];
    logic [FLT_W-1:0] flt_spad_q [FLT_DEPTH];
    logic [FLT_W-1:0] flt_spad_d [FLT_DEPTH];
    logic [IF_AW-1:0] if_wptr_q, if_wptr_d;
    logic [FCW-1:0]   flt_cnt_q, flt_cnt_d;
    logic             load_done_q, load_done_d;

    state_e           state_q, state_d;
    logic [N_W-1:0]   rows_left_q, rows_left_d;
    logic [IF_AW-1:0] base_q, base_d, off_q, off_d;
    logic [FLT_AW-1:0] j_q, j_d;
    logic             issued_q, issued_d, done_q, done_d;
    logic [IF_W-1:0]  if_rd_q, if_rd_d;
    logic [FLT_W-1:0] flt_rd_q, flt_rd_d;

    logic [FLT_AW-1:0] fs_m1;
    logic [SW-1:0]     row_len, addr_sum;
    logic [IF_AW-1:0]  rd_if_addr;
    logic              last_j, finish_row, can_issue;

    // A tagged word is held back while its tag queue is full so no row boundary is lost.
    assign if_pop  = if_avail && !if_clr
                   && (!rs_valid || (if_wptr_q != rs_head))
                   && (!if_head[WW-1] || rs_ready)
                   && (!if_head[WW-2] || re_ready);
    assign flt_pop = flt_avail && !flt_clr && !load_done_q;

    dl_fifo #(.W(WW), .DEPTH(IN_FIFO_DEPTH), .PAR(PAR_IF)) u_if_fifo (
        .clk(clk), .rst(rst), .clr(if_clr), .wen(if_wen), .din(if_din),
        .ready(if_ready), .ren(if_pop), .dout(if_head), .valid(if_avail));

    dl_fifo #(.W(FLT_W), .DEPTH(IN_FIFO_DEPTH), .PAR(PAR_FLT)) u_flt_fifo (
        .clk(clk), .rst(rst), .clr(flt_clr), .wen(flt_wen), .din(flt_din),
        .ready(flt_ready), .ren(flt_pop), .dout(flt_head), .valid(flt_avail));

    dl_fifo #(.W(IF_AW), .DEPTH(TAG_Q_DEPTH), .PAR(1)) u_row_start_q (
        .clk(clk), .rst(rst), .clr(1'b0), .wen(if_pop && if_head[WW-1]), .din(if_wptr_q),
        .ready(rs_ready), .ren(row_pop), .dout(rs_head), .valid(rs_valid));

    dl_fifo #(.W(IF_AW), .DEPTH(TAG_Q_DEPTH), .PAR(1)) u_row_end_q (
        .clk(clk), .rst(rst), .clr(1'b0), .wen(if_pop && if_head[WW-2]), .din(if_wptr_q),
        .ready(re_ready), .ren(row_pop), .dout(re_head), .valid(re_valid));

    // Drain FIFO heads into the scratchpads.
    always_comb begin
        if_spad_d   = if_spad_q;
        flt_spad_d  = flt_spad_q;
        if_wptr_d   = if_wptr_q;
        flt_cnt_d   = flt_cnt_q;
        load_done_d = load_done_q;
        if (if_pop) begin
            if_spad_d[if_wptr_q] = if_head[IF_W-1:0];
            if_wptr_d = (if_wptr_q == IF_AW'(IF_DEPTH - 1)) ? '0 : if_wptr_q + IF_AW'(1);
        end
        if (flt_pop) begin
            flt_spad_d[flt_cnt_q[FLT_AW-1:0]] = flt_head;
            flt_cnt_d = flt_cnt_q + FCW'(1);
            if (flt_cnt_q == FCW'(FLT_DEPTH - 1)) load_done_d = 1'b1;
        end
    end

    // Window address arithmetic; filter_size of 0 wraps to a full FLT_DEPTH window.
    always_comb begin
        fs_m1      = filter_size - FLT_AW'(1);
        addr_sum   = SW'(base_q) + SW'(off_q) + SW'(j_q);
        rd_if_addr = IF_AW'(addr_sum % SW'(IF_DEPTH));
        row_len    = SW'(re_head) + ((re_head >= base_q) ? SW'(0) : SW'(IF_DEPTH)) - SW'(base_q);
        last_j     = (j_q == fs_m1);
        finish_row = (SW'(off_q) + SW'(stride) + SW'(fs_m1)) > row_len;
        // The last issue of a window waits for the row end, since it decides row completion.
        can_issue  = ((rd_if_addr != if_wptr_q) || re_valid)
                   && (({1'b0, j_q} < flt_cnt_q) || load_done_q)
                   && (!last_j || re_valid);
    end

    // Read FSM: next state, window counters and operand capture.
    always_comb begin
        state_d     = state_q;
        rows_left_d = rows_left_q;
        base_d      = base_q;
        off_d       = off_q;
        j_d         = j_q;
        issued_d    = 1'b0;
        row_pop     = 1'b0;
        if_rd_d     = if_rd_q;
        flt_rd_d    = flt_rd_q;
        done_d      = (state_q == DONE);
        unique case (state_q)
            IDLE: if (start) begin
                rows_left_d = n;
                state_d     = WAIT;
            end
            WAIT: if (!stall && rs_valid) begin
                base_d  = rs_head;
                off_d   = '0;
                j_d     = '0;
                state_d = READ;
            end
            READ: if (!stall && can_issue) begin
                issued_d = 1'b1;
                if_rd_d  = if_spad_q[rd_if_addr];
                flt_rd_d = flt_spad_q[j_q];
                if (last_j) begin
                    j_d = '0;
                    if (finish_row) begin
                        row_pop     = 1'b1;
                        rows_left_d = rows_left_q - N_W'(1);
                        state_d     = (rows_left_q == N_W'(1)) ? DONE : WAIT;
                    end else begin
                        off_d = off_q + stride;
                    end
                end else begin
                    j_d = j_q + FLT_AW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_spad_q   <= '{default: '0};
            flt_spad_q  <= '{default: '0};
            if_wptr_q   <= '0;
            flt_cnt_q   <= '0;
            load_done_q <= 1'b0;
            state_q     <= IDLE;
            rows_left_q <= '0;
            base_q      <= '0;
            off_q       <= '0;
            j_q         <= '0;
            issued_q    <= 1'b0;
            done_q      <= 1'b0;
            if_rd_q     <= '0;
            flt_rd_q    <= '0;
        end else begin
            if_spad_q   <= if_spad_d;
            flt_spad_q  <= flt_spad_d;
            if_wptr_q   <= if_wptr_d;
            flt_cnt_q   <= flt_cnt_d;
            load_done_q <= load_done_d;
            state_q     <= state_d;
            rows_left_q <= rows_left_d;
            base_q      <= base_d;
            off_q       <= off_d;
            j_q         <= j_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
            if_rd_q     <= if_rd_d;
            flt_rd_q    <= flt_rd_d;
        end
    end

    assign if_dout  = if_rd_q;
    assign flt_dout = flt_rd_q;
    assign valid    = issued_q && (if_rd_q != '0);
    assign done     = done_q;

endmodule

// File: tb/tb_conv_data_loader.sv
// Directed bench for conv_data_loader: table of stream cases plus hand sequences.
module tb_conv_data_loader;

    logic        clk, rst, start, stall, if_clr, if_wen, flt_clr, flt_wen;
    logic [3:0]  stride, filter_size, n;
    logic [17:0] if_din;
    logic [15:0] flt_din;
    logic        if_ready, flt_ready, valid, done;
    logic [15:0] if_dout, flt_dout;

    conv_data_loader dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .if_clr(if_clr), .if_wen(if_wen), .flt_clr(flt_clr), .flt_wen(flt_wen),
        .stride(stride), .filter_size(filter_size), .n(n),
        .if_din(if_din), .flt_din(flt_din),
        .if_ready(if_ready), .flt_ready(flt_ready),
        .if_dout(if_dout), .flt_dout(flt_dout), .valid(valid), .done(done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit stall_at_edge = 1'b0;
    int got_if[$];
    int got_flt[$];
    int exp_if[$];
    int exp_flt[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_valid_cyc = 0;
    int stall_viol = 0;

    typedef struct {
        string name;
        int    rows;
        int    zero_pos;
        bit    do_stall;
        bit    late_flt;
        int    exp_pairs;
    } case_t;

    case_t cases[5];

    always @(posedge clk) begin
        cyc++;
        stall_at_edge = stall;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                got_if.push_back(int'(if_dout));
                got_flt.push_back(int'(flt_dout));
                last_valid_cyc = cyc;
                if (stall_at_edge) stall_viol++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; stall = 1'b0; if_clr = 1'b0; if_wen = 1'b0;
        flt_clr = 1'b0; flt_wen = 1'b0; if_din = '0; flt_din = '0;
        stride = 4'd4; filter_size = 4'd4; n = 4'd1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic clear_mon;
        got_if.delete(); got_flt.delete(); exp_if.delete(); exp_flt.delete();
        done_cnt = 0; done_cyc = 0; last_valid_cyc = 0; stall_viol = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_if_dout"}, int'(if_dout), 0);
        check({tag, "_flt_dout"}, int'(flt_dout), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_if_ready"}, int'(if_ready), 1);
        check({tag, "_flt_ready"}, int'(flt_ready), 1);
    endtask

    task automatic push_if(input int v, input bit s, input bit e);
        int t = 0;
        while (!if_ready && t < 400) begin tick(1); t++; end
        if (!if_ready) begin bound_fail("if_push"); return; end
        if_din = {s, e, 16'(v)};
        if_wen = 1'b1;
        tick(1);
        if_wen = 1'b0;
    endtask

    task automatic push_flt(input int v);
        int t = 0;
        while (!flt_ready && t < 400) begin tick(1); t++; end
        if (!flt_ready) begin bound_fail("flt_push"); return; end
        flt_din = 16'(v);
        flt_wen = 1'b1;
        tick(1);
        flt_wen = 1'b0;
    endtask

    task automatic load_filters;
        for (int i = 1; i <= 16; i++) push_flt(i);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (done_cnt == 0 && t < 600) begin tick(1); t++; end
        if (done_cnt == 0) bound_fail({nm, "_done_wait"});
        tick(8);
    endtask

    task automatic compare_stream(input string nm, input int req_pairs);
        int m;
        check({nm, "_count"}, got_if.size(), req_pairs);
        check({nm, "_model_count"}, got_if.size(), exp_if.size());
        m = (got_if.size() < exp_if.size()) ? got_if.size() : exp_if.size();
        for (int k = 0; k < m; k++) begin
            check($sformatf("%s_if[%0d]", nm, k), got_if[k], exp_if[k]);
            check($sformatf("%s_flt[%0d]", nm, k), got_flt[k], exp_flt[k]);
        end
        check({nm, "_done_pulses"}, done_cnt, 1);
        check({nm, "_done_lag"}, done_cyc - last_valid_cyc, 1);
        check({nm, "_stall_valid"}, stall_viol, 0);
    endtask

    task automatic run_case(input case_t c);
        int t;
        do_reset();
        clear_mon();
        n = 4'(c.rows);
        for (int r = 0; r < c.rows; r++) begin
            for (int k = 0; k < 8; k++) begin
                int v;
                v = r * 8 + k + 1;
                if (r == 0 && k == c.zero_pos) v = 0;
                if (v != 0) begin
                    exp_if.push_back(v);
                    exp_flt.push_back(k % 4 + 1);
                end
            end
        end
        if (!c.late_flt) load_filters();
        for (int k = 0; k < 8; k++) push_if((k == c.zero_pos) ? 0 : k + 1, k == 0, k == 7);
        pulse_start();
        for (int r = 1; r < c.rows; r++)
            for (int k = 0; k < 8; k++) push_if(r * 8 + k + 1, k == 0, k == 7);
        if (c.late_flt) begin
            tick(20);
            check({c.name, "_no_valid_before_flt"}, got_if.size(), 0);
            for (int i = 1; i <= 16; i++) begin
                push_flt(i);
                tick(3);
            end
        end
        if (c.do_stall) begin
            t = 0;
            while (got_if.size() < 2 && t < 200) begin tick(1); t++; end
            if (got_if.size() < 2) bound_fail({c.name, "_pre_stall"});
            stall = 1'b1;
            tick(3);
            stall = 1'b0;
        end
        wait_done(c.name);
        compare_stream(c.name, c.exp_pairs);
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        cases[0] = '{name: "basic",     rows: 1, zero_pos: -1, do_stall: 1'b0, late_flt: 1'b0, exp_pairs: 8};
        cases[1] = '{name: "zero_word", rows: 1, zero_pos: 2,  do_stall: 1'b0, late_flt: 1'b0, exp_pairs: 7};
        cases[2] = '{name: "two_rows",  rows: 2, zero_pos: -1, do_stall: 1'b0, late_flt: 1'b0, exp_pairs: 16};
        cases[3] = '{name: "stall",     rows: 1, zero_pos: -1, do_stall: 1'b1, late_flt: 1'b0, exp_pairs: 8};
        cases[4] = '{name: "late_flt",  rows: 1, zero_pos: -1, do_stall: 1'b0, late_flt: 1'b1, exp_pairs: 8};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 5; i++) run_case(cases[i]);

        // Blocked drain fills the FIFO; writes while not ready must be dropped.
        do_reset();
        clear_mon();
        load_filters();
        for (int k = 0; k < 12; k++) push_if(k + 1, k == 0, k == 11);
        for (int k = 0; k < 4; k++) push_if(21 + k, k == 0, k == 3);
        check("ovf_ready_low", int'(if_ready), 0);
        if_din = {1'b1, 1'b1, 16'd99};
        if_wen = 1'b1;
        tick(3);
        if_wen = 1'b0;
        check("ovf_ready_still_low", int'(if_ready), 0);
        for (int k = 0; k < 12; k++) begin exp_if.push_back(k + 1); exp_flt.push_back(k % 4 + 1); end
        for (int k = 0; k < 4; k++) begin exp_if.push_back(21 + k); exp_flt.push_back(k + 1); end
        n = 4'd2;
        pulse_start();
        wait_done("ovf");
        compare_stream("ovf", 16);

        // Clear together with write leaves the FIFO empty: exactly 4 more writes fill it.
        do_reset();
        clear_mon();
        for (int k = 0; k < 12; k++) push_if(k + 1, k == 0, k == 11);
        for (int k = 0; k < 4; k++) push_if(30 + k, 1'b0, 1'b0);
        check("clr_pre_full", int'(if_ready), 0);
        if_clr = 1'b1;
        if_wen = 1'b1;
        if_din = {2'b00, 16'd77};
        tick(1);
        if_clr = 1'b0;
        if_wen = 1'b0;
        check("clr_ready_high", int'(if_ready), 1);
        for (int k = 0; k < 3; k++) push_if(40 + k, 1'b0, 1'b0);
        check("clr_three_free", int'(if_ready), 1);
        push_if(43, 1'b0, 1'b0);
        check("clr_full_again", int'(if_ready), 0);

        rst = 1'b1;
        tick(1);
        check_reset_state("midrst");
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
